// File: rtl/stage_sequencer.sv
// Per-round stage sequencer: walks up to NUM_STAGES sub-blocks in fixed order through an
// en/start/done handshake and routes the shared memory write port to the active stage.
module stage_sequencer #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                             clock,
    input  logic                             nrst,
    input  logic                             go,
    input  logic [NUM_STAGES-1:0]            stage_mask,
    output logic [NUM_STAGES-1:0]            stage_en,
    output logic                             stage_start,
    input  logic [NUM_STAGES-1:0]            stage_done,
    input  logic [NUM_STAGES*ADDR_WIDTH-1:0] stage_addr,
    input  logic [NUM_STAGES-1:0]            stage_wr_en,
    input  logic [NUM_STAGES*WORD_WIDTH-1:0] stage_data,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic                             mem_wr_en,
    output logic [WORD_WIDTH-1:0]            mem_data_out,
    output logic [2:0]                       cur_stage,
    output logic                             busy,
    output logic                             round_done,
    output logic                             timeout_err
);

    localparam int unsigned SelWidth = $clog2(NUM_STAGES);
    localparam int unsigned CntWidth = $clog2(TIMEOUT);
    localparam logic [SelWidth-1:0] LastSel = SelWidth'(NUM_STAGES - 1);
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StEn,
        StStart,
        StWait,
        StNext,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [SelWidth-1:0]   idx_q, idx_d;
    logic [NUM_STAGES-1:0] mask_q, mask_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  err_q, err_d;

    // Per-stage views of the packed write-port buses
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_STAGES];
    logic [WORD_WIDTH-1:0] data_arr [NUM_STAGES];

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_unpack
        assign addr_arr[g] = stage_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[g] = stage_data[g*WORD_WIDTH +: WORD_WIDTH];
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: sequence through masked stages, abort on wait timeout
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    mask_d  = stage_mask;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = StCheck;
                end
            end
            StCheck: state_d = mask_q[idx_q] ? StEn : StNext;
            StEn:    state_d = StStart;
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // done wins over a timeout landing in the same cycle
                if (stage_done[idx_q]) begin
                    state_d = StNext;
                end else if (cnt_q == CntMax) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StNext: begin
                if (idx_q == LastSel) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StCheck;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs from registered state/idx; write port muxed to the selected stage
    always_comb begin
        stage_en = '0;
        if (state_q == StEn) begin
            stage_en[idx_q] = 1'b1;
        end
        stage_start  = (state_q == StStart);
        busy         = (state_q != StIdle);
        round_done   = (state_q == StDone);
        timeout_err  = err_q;
        cur_stage    = 3'(idx_q);
        mem_address  = addr_arr[idx_q];
        mem_data_out = data_arr[idx_q];
        mem_wr_en    = stage_wr_en[idx_q] &&
                       ((state_q == StEn) || (state_q == StStart) || (state_q == StWait));
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Per-round controller for a node's decision pipeline (route/action selection, aggregation scheduling, etc.).
- Runs up to NUM_STAGES sub-blocks in fixed order. Each sub-block uses the en/start/done handshake: it idles until en, arms on en (clearing its done), runs on start, and holds done high until the next en.
- Arbitrates the single shared memory write port (address, wr_en, data) so only the active stage can write.

Parameters:
NUM_STAGES, 4, number of sequenced sub-blocks (2..8)
ADDR_WIDTH, 11, shared memory address width
WORD_WIDTH, 16, shared memory data width
TIMEOUT, 255, maximum WAIT cycles per stage before abort (>=2)

Ports:
clock  in  1  system clock, rising edge
nrst  in  1  synchronous active-low reset
go  in  1  start a round; sampled only in IDLE
stage_mask  in  NUM_STAGES  bit i=1 runs stage i; latched on accepted go
stage_en  out  NUM_STAGES  one-hot arm pulse to stage i
stage_start  out  1  shared start pulse (only the armed stage reacts)
stage_done  in  NUM_STAGES  done level from each stage
stage_addr  in  NUM_STAGES*ADDR_WIDTH  per-stage write address, stage i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
stage_wr_en  in  NUM_STAGES  per-stage write enable
stage_data  in  NUM_STAGES*WORD_WIDTH  per-stage write data, same packing
mem_address  out  ADDR_WIDTH  shared port address
mem_wr_en  out  1  shared port write enable
mem_data_out  out  WORD_WIDTH  shared port data
cur_stage  out  3  current or failed stage index
busy  out  1  high whenever state != IDLE
round_done  out  1  one-cycle pulse at end of round
timeout_err  out  1  sticky abort flag, cleared on next accepted go

Behaviour:
- Reset (nrst=0 at a clock edge): state=IDLE, idx=0, mask_q=0, wait counter=0, timeout_err=0. All Moore outputs are then 0: stage_en, stage_start, busy, round_done, mem_wr_en. cur_stage=0.
- Reset mid-round aborts immediately: no further en/start. Sub-blocks rely on their own nrst.
- States: IDLE, CHECK, EN, START, WAIT, NEXT, DONE.
- IDLE: when go=1, latch mask_q=stage_mask, idx=0, timeout_err=0, go to CHECK. go in any other state is ignored.
- CHECK: mask_q[idx]=1 -> EN; otherwise -> NEXT.
- EN: stage_en[idx]=1 for exactly this cycle. -> START.
- START: stage_start=1 for exactly this cycle; clear wait counter. -> WAIT.
- WAIT: if stage_done[idx]=1 -> NEXT. Else if counter==TIMEOUT-1 -> set timeout_err and go to DONE, holding idx so cur_stage shows the failed stage. Else increment the counter.
  - done has priority over timeout in the same cycle.
  - stage_done is sampled only in WAIT; stale done from a previous round is cleared by the stage on en.
- NEXT: if idx==NUM_STAGES-1 -> DONE; else idx+1 -> CHECK.
- DONE: round_done=1 for one cycle. -> IDLE. idx and timeout_err hold until the next go.
- Outputs are decoded from registered state/idx only; no combinational path from go or stage_done to them.
- cur_stage = idx, zero-extended.
- Memory arbitration (combinational):
  - mem_address = stage_addr slice[idx]; mem_data_out = stage_data slice[idx].
  - mem_wr_en = stage_wr_en[idx] while state is EN, START or WAIT; 0 otherwise.
  - Writes from non-selected stages are dropped; so are writes from the selected stage in any other state.
- Timing:
  - Latency go -> stage_en[first enabled stage] = 2 cycles when stage 0 is enabled.
  - Each skipped stage costs 2 cycles (CHECK+NEXT).
  - Each run stage costs 4 + W cycles, where W = WAIT cycles.
- All-zero mask: no en/start issued. With NUM_STAGES=4, round_done is high in the 9th cycle after the edge that accepted go.

Test Plan:
- Reset mid-WAIT (nrst=0 one edge) -> next cycle busy=0, stage_en=0, mem_wr_en=0, timeout_err=0; go then starts a clean round at stage 0.
- NUM_STAGES=4, mask=4'b1111, each stage model raises done 5 cycles after start -> en pulses in order 0,1,2,3; one start per stage; round_done once; timeout_err=0; total 4*(4+5)=36 cycles to DONE.
- mask=4'b0101 -> only stage_en[0] and stage_en[2] pulse; stages 1,3 never armed; a stage 1 wr_en=1 with addr 0x002 never reaches mem_wr_en.
- Stage 2 never raises done, TIMEOUT=255 -> after 255 WAIT cycles timeout_err=1, cur_stage=2, round_done pulses, stage 3 never armed; the next go clears timeout_err.
- Stage 0 asserts wr_en with addr 0x002, data 0x0001 during WAIT -> mem_address=0x002, mem_data_out=0x0001, mem_wr_en=1 in the same cycle; a go pulse while busy=1 has no effect.
- mask=0, go -> no stage_en, no stage_start; round_done pulse 9 cycles after go accepted.
